// File: rtl/bit_extract_ctrl_if.sv
// ---------------------------------------------------------------------------
// bit_extract_ctrl_if
//   Bundles the FIFO read side and the field request/response side of the
//   bit extractor into one interface.
//
//   slave  modport : the extractor (consumes requests and FIFO data)
//   master modport : the environment (FIFO plus field requester)
//
//   Signals
//     flush       sync clear of buffer, pending request and in-flight read
//     fifo_empty  FIFO has no word to pop
//     fifo_pop    pop strobe; word appears on fifo_data the next cycle
//     fifo_data   FIFO read data (registered inside the FIFO)
//     reqin       field request strobe
//     reqlen      requested field length, 0..15
//     req_ready   extractor accepts a request this cycle
//     pushout     one-cycle pulse, field valid on lenout/dataout
//     lenout      length of the returned field
//     dataout     returned field, right-justified, upper bits zero
//     bit_count   number of valid bits currently buffered
// ---------------------------------------------------------------------------
interface bit_extract_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 15,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 7
);
  logic              flush;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_data;
  logic              reqin;
  logic [LEN_W-1:0]  reqlen;
  logic              req_ready;
  logic              pushout;
  logic [LEN_W-1:0]  lenout;
  logic [OUT_W-1:0]  dataout;
  logic [CNT_W-1:0]  bit_count;

  modport slave (
    input  flush,
    input  fifo_empty,
    input  fifo_data,
    input  reqin,
    input  reqlen,
    output fifo_pop,
    output req_ready,
    output pushout,
    output lenout,
    output dataout,
    output bit_count
  );

  modport master (
    output flush,
    output fifo_empty,
    output fifo_data,
    output reqin,
    output reqlen,
    input  fifo_pop,
    input  req_ready,
    input  pushout,
    input  lenout,
    input  dataout,
    input  bit_count
  );
endinterface

// File: rtl/bit_extract_ctrl.sv
// ---------------------------------------------------------------------------
// bit_extract_ctrl
//   Read controller and bit extractor for a 32-bit word FIFO. Words are
//   popped into a 64-bit left-aligned bit buffer (oldest bit at the MSB) and
//   variable-length fields of 0..15 bits are returned MSB-first. Requests
//   that need more bits than are buffered are parked in a WAIT state until
//   the bits have landed.
//
//   Ports
//     clock   rising-edge clock
//     reset   asynchronous, active-high reset
//     bus     bit_extract_ctrl_if.slave (FIFO side + request/response side)
//
//   Timing
//     - fifo_pop is combinational from registered state and the FIFO flag;
//       the popped word is appended on the following edge.
//     - pushout/lenout/dataout are registered; a field is returned on the
//       edge after the request when enough bits are buffered, otherwise on
//       the edge after the edge at which the missing bits land.
//     - flush clears everything except the held lenout/dataout values.
// ---------------------------------------------------------------------------
module bit_extract_ctrl #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 15,
  parameter int LEN_W  = 4,
  parameter int BUF_W  = 64,
  parameter int CNT_W  = 7
) (
  input  logic               clock,
  input  logic               reset,
  bit_extract_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Field extraction: the top OUT_W bits of the buffer, right-shifted so the
  // requested len MSBs end up right-justified. len = 0 shifts everything out.
  // -------------------------------------------------------------------------
  function automatic logic [OUT_W-1:0] extract_field(
    input logic [BUF_W-1:0] buf_v,
    input logic [LEN_W-1:0] len
  );
    logic [OUT_W-1:0] top;
    logic [LEN_W:0]   sh;
    top = buf_v[BUF_W-1 -: OUT_W];
    sh  = (LEN_W+1)'(OUT_W) - {1'b0, len};
    return top >> sh;
  endfunction

  // -------------------------------------------------------------------------
  // Word placement: a new word goes directly below the rem bits that remain
  // valid after this cycle's consume. rem never exceeds DATA_W because a pop
  // is only issued while bit_count <= DATA_W.
  // -------------------------------------------------------------------------
  function automatic logic [BUF_W-1:0] place_word(
    input logic [DATA_W-1:0] word,
    input logic [CNT_W-1:0]  rem
  );
    return {word, {(BUF_W-DATA_W){1'b0}}} >> rem;
  endfunction

  // Bit buffer state
  logic [BUF_W-1:0] buffer;
  logic [CNT_W-1:0] count;
  logic             rd_pending;

  // Request FSM state and registered outputs
  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic             ready_p1;
  logic             vld_p1;
  logic [LEN_W-1:0] len_p1;
  logic [OUT_W-1:0] data_p1;

  // Combinational decisions for the current cycle
  logic             serve;
  logic [LEN_W-1:0] serve_len;
  logic [LEN_W-1:0] take_len;
  logic [CNT_W-1:0] rem;
  logic             pop_c;
  logic [BUF_W-1:0] buf_next;
  logic [CNT_W-1:0] cnt_next;

  // A request is served against the start-of-cycle count only, so a word
  // landing this cycle cannot satisfy it until the next cycle.
  always_comb begin
    serve     = 1'b0;
    serve_len = len_q;
    if (state == IDLE) begin
      serve_len = bus.reqin ? bus.reqlen : '0;
      serve     = bus.reqin && (CNT_W'(bus.reqlen) <= count);
    end else begin
      serve_len = len_q;
      serve     = (CNT_W'(len_q) <= count);
    end
  end

  assign take_len = serve ? serve_len : '0;
  assign rem      = count - CNT_W'(take_len);

  // Consume from the old bits first, then append the arriving word below
  // whatever remains. Bits below the valid region are always zero, so the
  // OR merge is safe.
  always_comb begin
    buf_next = buffer << take_len;
    cnt_next = rem;
    if (rd_pending) begin
      buf_next = buf_next | place_word(bus.fifo_data, rem);
      cnt_next = rem + CNT_W'(DATA_W);
    end
  end

  // At most one read in flight, and only when the buffer can absorb a
  // full word even if nothing is consumed.
  assign pop_c = !reset && !bus.fifo_empty && !rd_pending && !bus.flush &&
                 (count <= CNT_W'(DATA_W));

  // -------------------------------------------------------------------------
  // Stage boundary: bit buffer and read tracking
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buffer     <= '0;
      count      <= '0;
      rd_pending <= 1'b0;
    end else if (bus.flush) begin
      // An in-flight word arriving this cycle is dropped with the rest.
      buffer     <= '0;
      count      <= '0;
      rd_pending <= 1'b0;
    end else begin
      buffer     <= buf_next;
      count      <= cnt_next;
      rd_pending <= pop_c;
    end
  end

  // -------------------------------------------------------------------------
  // Stage boundary: request FSM and registered field outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      len_q    <= '0;
      ready_p1 <= 1'b1;
      vld_p1   <= 1'b0;
      len_p1   <= '0;
      data_p1  <= '0;
    end else if (bus.flush) begin
      // lenout/dataout keep their last value; a request in this cycle is lost.
      state    <= IDLE;
      ready_p1 <= 1'b1;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= serve;
      if (serve) begin
        len_p1  <= serve_len;
        data_p1 <= extract_field(buffer, serve_len);
      end
      case (state)
        IDLE: begin
          if (bus.reqin && !serve) begin
            len_q    <= bus.reqlen;
            state    <= WAIT;
            ready_p1 <= 1'b0;
          end
        end
        WAIT: begin
          if (serve) begin
            state    <= IDLE;
            ready_p1 <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          ready_p1 <= 1'b1;
        end
      endcase
    end
  end

  assign bus.fifo_pop  = pop_c;
  assign bus.req_ready = ready_p1;
  assign bus.pushout   = vld_p1;
  assign bus.lenout    = len_p1;
  assign bus.dataout   = data_p1;
  assign bus.bit_count = count;

endmodule

// File: tb/tb_bit_extract_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bit_extract_ctrl
//   Bench for bit_extract_ctrl. A queue-based FIFO with a registered empty
//   flag and registered read data feeds the extractor; every word written is
//   also appended to a bit-level reference stream, and each accepted request
//   takes its expected field from that stream into a scoreboard.
// ---------------------------------------------------------------------------
module tb_bit_extract_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bit_extract_ctrl_if ifc ();

  bit_extract_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  // FIFO model
  logic [31:0] fifo_q[$];
  int          pop_cnt = 0;

  always @(posedge clock) begin
    if (ifc.fifo_pop) begin
      pop_cnt++;
      if (fifo_q.size() > 0) ifc.fifo_data <= fifo_q.pop_front();
    end
    ifc.fifo_empty <= (fifo_q.size() == 0);
  end

  // Reference bit stream and scoreboard
  bit          model_bits[$];
  logic [14:0] exp_d_q[$];
  logic [3:0]  exp_l_q[$];
  logic [14:0] e_d;
  logic [3:0]  e_l;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic fifo_write(input logic [31:0] w);
    fifo_q.push_back(w);
    for (int i = 31; i >= 0; i--) model_bits.push_back(w[i]);
  endtask

  task automatic push_exp(input int len);
    logic [14:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v = {v[13:0], model_bits.pop_front()};
    exp_l_q.push_back(4'(len));
    exp_d_q.push_back(v);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_flush();
    step();
    ifc.flush = 1'b1;
    step();
    ifc.flush = 1'b0;
    model_bits.delete();
  endtask

  task automatic wait_count(input int target);
    for (int k = 0; k < 40; k++) begin
      if (ifc.bit_count == 7'(target)) break;
      step();
    end
  endtask

  task automatic test_reset();
    ifc.flush  = 1'b0;
    ifc.reqin  = 1'b0;
    ifc.reqlen = '0;
    repeat (2) @(negedge clock);
    n_tests++;
    if (ifc.pushout !== 1'b0 || ifc.lenout !== 4'd0 || ifc.dataout !== 15'd0 ||
        ifc.bit_count !== 7'd0 || ifc.req_ready !== 1'b1 || ifc.fifo_pop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: push=%b len=%0d data=%h cnt=%0d rdy=%b pop=%b required 0 0 0 0 1 0",
               ifc.pushout, ifc.lenout, ifc.dataout, ifc.bit_count, ifc.req_ready, ifc.fifo_pop);
    end
    step();
    reset = 1'b0;
    fifo_write(32'hA5A5_0000);
    wait_count(32);
    n_tests++;
    if (ifc.bit_count !== 7'd32) begin
      n_fail++;
      $display("FAIL reset_fill: bit_count=%0d required 32", ifc.bit_count);
    end
    ifc.reqin  = 1'b1;
    ifc.reqlen = 4'd4;
    push_exp(4);
    step();
    ifc.reqin = 1'b0;
    @(negedge clock);
    n_tests++;
    if (ifc.pushout !== 1'b1 || exp_d_q.size() == 0) begin
      n_fail++;
      $display("FAIL reset_field: pushout=%b required 1", ifc.pushout);
    end else begin
      e_l = exp_l_q.pop_front();
      e_d = exp_d_q.pop_front();
      if (ifc.lenout !== e_l || ifc.dataout !== e_d || ifc.bit_count !== 7'd28) begin
        n_fail++;
        $display("FAIL reset_field: len=%0d data=%h cnt=%0d required len=%0d data=%h cnt=28",
                 ifc.lenout, ifc.dataout, ifc.bit_count, e_l, e_d);
      end
    end
  endtask

  task automatic test_straddle();
    int len;
    do_flush();
    fifo_write(32'hFFFF_FFF0);
    fifo_write(32'h8000_0000);
    wait_count(64);
    n_tests++;
    if (ifc.bit_count !== 7'd64) begin
      n_fail++;
      $display("FAIL straddle_fill: bit_count=%0d required 64", ifc.bit_count);
    end
    ifc.reqin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      len = (i < 7) ? 4 : 5;
      ifc.reqlen = 4'(len);
      push_exp(len);
      @(posedge clock);
      @(negedge clock);
      n_tests++;
      if (ifc.pushout !== 1'b1 || exp_d_q.size() == 0) begin
        n_fail++;
        $display("FAIL straddle_field%0d: pushout=%b required 1", i, ifc.pushout);
      end else begin
        e_l = exp_l_q.pop_front();
        e_d = exp_d_q.pop_front();
        if (ifc.lenout !== e_l || ifc.dataout !== e_d) begin
          n_fail++;
          $display("FAIL straddle_field%0d: len=%0d data=%h required len=%0d data=%h",
                   i, ifc.lenout, ifc.dataout, e_l, e_d);
        end
      end
    end
    ifc.reqin = 1'b0;
    n_tests++;
    if (ifc.bit_count !== 7'd31) begin
      n_fail++;
      $display("FAIL straddle_count: bit_count=%0d required 31", ifc.bit_count);
    end
  endtask

  task automatic test_stall();
    do_flush();
    ifc.reqin  = 1'b1;
    ifc.reqlen = 4'd15;
    step();
    ifc.reqin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_tests++;
      if (ifc.req_ready !== 1'b0 || ifc.pushout !== 1'b0 || ifc.fifo_pop !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_wait%0d: rdy=%b push=%b pop=%b required 0 0 0",
                 i, ifc.req_ready, ifc.pushout, ifc.fifo_pop);
      end
    end
    step();
    fifo_write(32'h1234_5678);
    push_exp(15);
    wait_count(32);
    n_tests++;
    if (ifc.bit_count !== 7'd32 || ifc.pushout !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_land: cnt=%0d push=%b required cnt=32 push=0", ifc.bit_count, ifc.pushout);
    end
    step();
    n_tests++;
    if (ifc.pushout !== 1'b1 || exp_d_q.size() == 0) begin
      n_fail++;
      $display("FAIL stall_field: pushout=%b required 1", ifc.pushout);
    end else begin
      e_l = exp_l_q.pop_front();
      e_d = exp_d_q.pop_front();
      if (ifc.lenout !== e_l || ifc.dataout !== e_d || ifc.bit_count !== 7'd17 || ifc.req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_field: len=%0d data=%h cnt=%0d rdy=%b required len=%0d data=%h cnt=17 rdy=1",
                 ifc.lenout, ifc.dataout, ifc.bit_count, ifc.req_ready, e_l, e_d);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lens[6]   = '{15, 15, 15, 15, 3, 15};
    int counts[6] = '{49, 34, 19, 4, 33, 18};
    int base;
    do_flush();
    for (int i = 0; i < 3; i++) fifo_write($urandom);
    wait_count(64);
    repeat (3) step();
    n_tests++;
    if (ifc.bit_count !== 7'd64 || ifc.fifo_pop !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_full: cnt=%0d pop=%b required cnt=64 pop=0", ifc.bit_count, ifc.fifo_pop);
    end
    base = pop_cnt;
    ifc.reqin = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ifc.reqlen = 4'(lens[i]);
      push_exp(lens[i]);
      @(posedge clock);
      @(negedge clock);
      n_tests++;
      if (ifc.pushout !== 1'b1 || exp_d_q.size() == 0) begin
        n_fail++;
        $display("FAIL b2b_field%0d: pushout=%b required 1", i, ifc.pushout);
      end else begin
        e_l = exp_l_q.pop_front();
        e_d = exp_d_q.pop_front();
        if (ifc.lenout !== e_l || ifc.dataout !== e_d || ifc.bit_count !== 7'(counts[i])) begin
          n_fail++;
          $display("FAIL b2b_field%0d: len=%0d data=%h cnt=%0d required len=%0d data=%h cnt=%0d",
                   i, ifc.lenout, ifc.dataout, ifc.bit_count, e_l, e_d, counts[i]);
        end
      end
    end
    ifc.reqin = 1'b0;
    n_tests++;
    if (pop_cnt - base != 1) begin
      n_fail++;
      $display("FAIL b2b_pops: pops=%0d required 1", pop_cnt - base);
    end
  endtask

  task automatic test_zero_len();
    step();
    ifc.reqin  = 1'b1;
    ifc.reqlen = 4'd0;
    push_exp(0);
    step();
    ifc.reqin = 1'b0;
    n_tests++;
    if (ifc.pushout !== 1'b1 || exp_d_q.size() == 0) begin
      n_fail++;
      $display("FAIL zero_len: pushout=%b required 1", ifc.pushout);
    end else begin
      e_l = exp_l_q.pop_front();
      e_d = exp_d_q.pop_front();
      if (ifc.lenout !== e_l || ifc.dataout !== e_d || ifc.bit_count !== 7'd18) begin
        n_fail++;
        $display("FAIL zero_len: len=%0d data=%h cnt=%0d required len=%0d data=%h cnt=18",
                 ifc.lenout, ifc.dataout, ifc.bit_count, e_l, e_d);
      end
    end
  endtask

  task automatic test_flush();
    bit seen;
    do_flush();
    fifo_write(32'hDEAD_BEEF);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clock);
      seen = ifc.fifo_pop;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL flush_pop: fifo_pop never rose, required 1");
    end
    @(posedge clock);
    #1;
    ifc.flush  = 1'b1;
    ifc.reqin  = 1'b1;
    ifc.reqlen = 4'd1;
    step();
    ifc.flush = 1'b0;
    ifc.reqin = 1'b0;
    model_bits.delete();
    @(negedge clock);
    n_tests++;
    if (ifc.bit_count !== 7'd0 || ifc.pushout !== 1'b0 || ifc.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_clear: cnt=%0d push=%b rdy=%b required 0 0 1", ifc.bit_count, ifc.pushout, ifc.req_ready);
    end
    repeat (3) step();
    n_tests++;
    if (ifc.bit_count !== 7'd0 || ifc.pushout !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_discard: cnt=%0d push=%b required 0 0", ifc.bit_count, ifc.pushout);
    end
    ifc.reqin  = 1'b1;
    ifc.reqlen = 4'd8;
    step();
    ifc.reqin = 1'b0;
    repeat (3) @(negedge clock);
    n_tests++;
    if (ifc.req_ready !== 1'b0 || ifc.fifo_pop !== 1'b0 || ifc.pushout !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_wait: rdy=%b pop=%b push=%b required 0 0 0", ifc.req_ready, ifc.fifo_pop, ifc.pushout);
    end
    step();
    fifo_write(32'hC3A5_0F0F);
    push_exp(8);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      seen = ifc.pushout;
    end
    n_tests++;
    if (!seen || exp_d_q.size() == 0) begin
      n_fail++;
      $display("FAIL flush_field: pushout=%b required 1", seen);
    end else begin
      e_l = exp_l_q.pop_front();
      e_d = exp_d_q.pop_front();
      if (ifc.lenout !== e_l || ifc.dataout !== e_d || ifc.bit_count !== 7'd24) begin
        n_fail++;
        $display("FAIL flush_field: len=%0d data=%h cnt=%0d required len=%0d data=%h cnt=24",
                 ifc.lenout, ifc.dataout, ifc.bit_count, e_l, e_d);
      end
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    do_flush();
    ifc.reqin  = 1'b1;
    ifc.reqlen = 4'd15;
    step();
    ifc.reqin = 1'b0;
    fifo_write(32'h8765_4321);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clock);
      seen = ifc.fifo_pop;
    end
    @(posedge clock);
    #2;
    n_tests++;
    if (!seen || ifc.req_ready !== 1'b0 || ifc.lenout !== 4'd8) begin
      n_fail++;
      $display("FAIL areset_pre: popped=%b rdy=%b len=%0d required 1 0 8", seen, ifc.req_ready, ifc.lenout);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (ifc.pushout !== 1'b0 || ifc.lenout !== 4'd0 || ifc.dataout !== 15'd0 ||
        ifc.bit_count !== 7'd0 || ifc.req_ready !== 1'b1 || ifc.fifo_pop !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_now: push=%b len=%0d data=%h cnt=%0d rdy=%b pop=%b required 0 0 0 0 1 0",
               ifc.pushout, ifc.lenout, ifc.dataout, ifc.bit_count, ifc.req_ready, ifc.fifo_pop);
    end
    model_bits.delete();
    repeat (2) step();
    reset = 1'b0;
    repeat (3) step();
    n_tests++;
    if (ifc.bit_count !== 7'd0 || ifc.pushout !== 1'b0 || ifc.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_after: cnt=%0d push=%b rdy=%b required 0 0 1", ifc.bit_count, ifc.pushout, ifc.req_ready);
    end
    n_tests++;
    if (exp_d_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d fields never returned, required 0", exp_d_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_straddle();
    test_stall();
    test_back_to_back();
    test_zero_len();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
